// File: rtl/bus_pkg.sv
// Shared definitions for the bus_slave_buf result buffer.
//   - register offsets within the 16-word decode window
//   - CTRL / STATUS bit positions
//   - fill-state FSM encoding and a debug snapshot struct
package bus_pkg;

  localparam logic [3:0] DATA_BASE  = 4'h0;
  localparam logic [3:0] COUNT_OFS  = 4'h8;
  localparam logic [3:0] CTRL_OFS   = 4'h9;
  localparam logic [3:0] STATUS_OFS = 4'hA;

  localparam int CTRL_INT_EN   = 0;
  localparam int CTRL_SOFT_CLR = 1;

  localparam int STAT_FULL = 0;
  localparam int STAT_PEND = 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_FILLING = 2'b01,
    ST_FULL    = 2'b10
  } buf_state_e;

  // Snapshot of the control state, kept together so checkers can bind to it.
  typedef struct packed {
    buf_state_e  state;
    logic [3:0]  count;
    logic        pending;
    logic        int_en;
  } buf_dbg_t;

endpackage

// File: rtl/slave_buf_ram.sv
// Result storage: DEPTH x DATA_W register array.
//   clk, rst_n : clock, asynchronous active-low reset (clears every entry)
//   we, waddr, wdata : single write port, written on the rising edge
//   raddr, rdata     : combinational read port
module slave_buf_ram #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_slave_buf.sv
// Bus slave that collects the master's write stream into a small result
// buffer, tracks the fill level and interrupts the host when it is full.
//
// Ports:
//   clk, reset_n  : clock (rising edge), asynchronous active-low reset
//   S_sel, S_wr   : access strobe and direction (1 = write)
//   S_address     : word offset, only [3:0] decoded
//   S_din         : write data
//   op_clear      : synchronous clear of count / state / pending
//   S_dout        : registered read data, 0 when no read was taken
//   s_interrupt   : pending & int_en
//   s_full        : buffer is in the FULL state
//
// Bus handshake: an access happens at every rising edge where S_sel is 1.
// There is no ready/stall; the slave always accepts with zero wait states,
// and read data appears on S_dout for exactly the one cycle after the edge
// that sampled the read.
module bus_slave_buf
  import bus_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              S_sel,
  input  logic              S_wr,
  input  logic [ADDR_W-1:0] S_address,
  input  logic [DATA_W-1:0] S_din,
  input  logic              op_clear,
  output logic [DATA_W-1:0] S_dout,
  output logic              s_interrupt,
  output logic              s_full
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_MAX = 4'(DEPTH);

  logic [3:0]        offset;
  logic              wr_acc, rd_acc;
  logic              data_hit, data_we, ctrl_we, status_we, clear;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_val;

  buf_state_e state, state_nxt;
  logic [3:0] count, count_nxt;
  logic       pending, pending_nxt;
  logic       int_en;
  buf_dbg_t   fsm_dbg;

  assign offset    = S_address[3:0];
  assign wr_acc    = S_sel & S_wr;
  assign rd_acc    = S_sel & ~S_wr;
  assign data_hit  = (offset < CNT_MAX);
  assign data_we   = wr_acc & data_hit;
  assign ctrl_we   = wr_acc & (offset == CTRL_OFS);
  assign status_we = wr_acc & (offset == STATUS_OFS);
  // A soft clear through CTRL behaves exactly like the op_clear pin.
  assign clear     = op_clear | (ctrl_we & S_din[CTRL_SOFT_CLR]);

  slave_buf_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (data_we),
    .waddr (offset[IDX_W-1:0]),
    .wdata (S_din),
    .raddr (offset[IDX_W-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_EMPTY;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
    end
  end

  // Clear wins over a simultaneous data write: the data still lands in the
  // RAM (data_we is independent of clear) but the bookkeeping restarts.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_nxt = pending;
    if (clear) begin
      state_nxt   = ST_EMPTY;
      count_nxt   = '0;
      pending_nxt = 1'b0;
    end else begin
      // Count saturates; writes past full still overwrite data.
      if (data_we && (count != CNT_MAX)) begin
        count_nxt = count + 4'd1;
      end
      case (state)
        ST_EMPTY: begin
          if (data_we) begin
            if (count_nxt == CNT_MAX) begin
              state_nxt   = ST_FULL;
              pending_nxt = 1'b1;
            end else begin
              state_nxt = ST_FILLING;
            end
          end
        end
        ST_FILLING: begin
          if (data_we && (count_nxt == CNT_MAX)) begin
            state_nxt   = ST_FULL;
            pending_nxt = 1'b1;
          end
        end
        ST_FULL: begin
          state_nxt = ST_FULL;
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
      if (status_we && S_din[STAT_PEND]) begin
        pending_nxt = 1'b0;
      end
    end
  end

  // int_en survives clears; a CTRL write always loads it from bit 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_en <= 1'b0;
    end else if (ctrl_we) begin
      int_en <= S_din[CTRL_INT_EN];
    end
  end

  always_comb begin
    rd_val = '0;
    if (data_hit) begin
      rd_val = ram_rdata;
    end else begin
      case (offset)
        COUNT_OFS:  rd_val[3:0]        = count;
        CTRL_OFS:   rd_val[CTRL_INT_EN] = int_en;
        STATUS_OFS: begin
          rd_val[STAT_FULL] = s_full;
          rd_val[STAT_PEND] = pending;
        end
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      S_dout <= '0;
    end else begin
      S_dout <= rd_acc ? rd_val : '0;
    end
  end

  assign s_full      = (state == ST_FULL);
  assign s_interrupt = pending & int_en;

  assign fsm_dbg = '{state: state, count: count, pending: pending, int_en: int_en};

  // Upper address bits are outside the decode window; the debug snapshot is
  // only observed by external checkers.
  logic unused_bits;
  assign unused_bits = ^{S_address[ADDR_W-1:4], fsm_dbg};

endmodule

// File: tb/tb_bus_slave_buf.sv
module tb_bus_slave_buf;

  logic        clk;
  logic        reset_n;
  logic        S_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic        op_clear;
  logic [31:0] S_dout;
  logic        s_interrupt;
  logic        s_full;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  bus_slave_buf dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .S_sel       (S_sel),
    .S_wr        (S_wr),
    .S_address   (S_address),
    .S_din       (S_din),
    .op_clear    (op_clear),
    .S_dout      (S_dout),
    .s_interrupt (s_interrupt),
    .s_full      (s_full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Tasks are entered 1 time unit after a rising edge and leave at the same
  // phase of the edge that took the access.
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    S_sel = 1'b1; S_wr = 1'b1; S_address = addr; S_din = data;
    @(posedge clk); #1;
    S_sel = 1'b0; S_wr = 1'b0; S_din = '0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    S_sel = 1'b1; S_wr = 1'b0; S_address = addr;
    @(posedge clk); #1;
    S_sel = 1'b0;
    data = S_dout;
  endtask

  task automatic fill_all();
    for (int n = 0; n < 8; n++) begin
      bus_write(8'(n), 32'(32'h11111111 * (n + 1)));
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; S_sel = 1'b0; S_wr = 1'b0; S_address = '0;
    S_din = '0; op_clear = 1'b0;
    idle(3);
    check("rst_dout", S_dout, 32'h0);
    check("rst_int", 32'(s_interrupt), 32'h0);
    check("rst_full", 32'(s_full), 32'h0);
    reset_n = 1'b1;
    idle(1);
    bus_read(8'h08, rd); check("rst_count", rd, 32'h0);
    bus_read(8'h0A, rd); check("rst_status", rd, 32'h0);
    bus_read(8'h05, rd); check("rst_data5", rd, 32'h0);

    // Fill with interrupt enabled
    bus_write(8'h09, 32'h1);
    bus_read(8'h09, rd); check("ctrl_rd", rd, 32'h1);
    for (int n = 0; n < 7; n++) begin
      bus_write(8'(n), 32'(32'h11111111 * (n + 1)));
      exp_q.push_back(32'(32'h11111111 * (n + 1)));
    end
    check("full_before_8th", 32'(s_full), 32'h0);
    check("int_before_8th", 32'(s_interrupt), 32'h0);
    bus_write(8'h07, 32'h88888888);
    exp_q.push_back(32'h88888888);
    check("full_at_8th", 32'(s_full), 32'h1);
    check("int_at_8th", 32'(s_interrupt), 32'h1);
    bus_read(8'h08, rd); check("count_full", rd, 32'h8);
    bus_read(8'h0A, rd); check("status_full", rd, 32'h3);

    // Readback latency and idle zero
    bus_read(8'h03, rd); check("lat_rd3", rd, 32'h44444444);
    idle(1);
    check("lat_idle_zero", S_dout, 32'h0);

    // Full readback against scoreboard
    for (int n = 0; n < 8; n++) begin
      bus_read(8'(n), rd);
      check($sformatf("data%0d", n), rd, exp_q.pop_front());
    end

    // Saturation
    bus_write(8'h00, 32'hDEADBEEF);
    bus_read(8'h00, rd); check("sat_data0", rd, 32'hDEADBEEF);
    bus_read(8'h08, rd); check("sat_count", rd, 32'h8);
    bus_read(8'h0A, rd); check("sat_status", rd, 32'h3);

    // W1C on pending
    bus_write(8'h0A, 32'h2);
    check("w1c_int", 32'(s_interrupt), 32'h0);
    check("w1c_full", 32'(s_full), 32'h1);
    bus_read(8'h0A, rd); check("w1c_status", rd, 32'h1);

    // Soft clear with int_en=0, refill, then unmask
    bus_write(8'h09, 32'h2);
    bus_read(8'h08, rd); check("clr_count", rd, 32'h0);
    bus_read(8'h09, rd); check("clr_ctrl", rd, 32'h0);
    check("clr_full", 32'(s_full), 32'h0);
    fill_all();
    check("mask_full", 32'(s_full), 32'h1);
    check("mask_int", 32'(s_interrupt), 32'h0);
    bus_read(8'h0A, rd); check("mask_status", rd, 32'h3);
    bus_write(8'h09, 32'h1);
    check("unmask_int", 32'(s_interrupt), 32'h1);

    // op_clear together with a data write
    op_clear = 1'b1;
    bus_write(8'h02, 32'hA5A5A5A5);
    op_clear = 1'b0;
    check("opclr_full", 32'(s_full), 32'h0);
    check("opclr_int", 32'(s_interrupt), 32'h0);
    bus_read(8'h02, rd); check("opclr_data2", rd, 32'hA5A5A5A5);
    bus_read(8'h08, rd); check("opclr_count", rd, 32'h0);
    bus_read(8'h0A, rd); check("opclr_status", rd, 32'h0);
    bus_read(8'h09, rd); check("opclr_ctrl", rd, 32'h1);
    bus_write(8'h05, 32'h55550000);
    bus_read(8'h08, rd); check("one_count", rd, 32'h1);
    check("one_full", 32'(s_full), 32'h0);

    // Soft clear through CTRL=0x3 after a full buffer
    for (int n = 0; n < 7; n++) begin
      bus_write(8'(n + 1), 32'(32'h11111111 * (n + 2)));
    end
    check("soft_pre_full", 32'(s_full), 32'h1);
    check("soft_pre_int", 32'(s_interrupt), 32'h1);
    bus_write(8'h09, 32'h3);
    check("soft_full", 32'(s_full), 32'h0);
    check("soft_int", 32'(s_interrupt), 32'h0);
    bus_read(8'h08, rd); check("soft_count", rd, 32'h0);
    bus_read(8'h09, rd); check("soft_ctrl", rd, 32'h1);
    bus_read(8'h07, rd); check("soft_keep7", rd, 32'h88888888);

    // Reserved / read-only offsets and high address bits
    bus_write(8'h0B, 32'hFFFFFFFF);
    bus_read(8'h0B, rd); check("resv_b", rd, 32'h0);
    bus_read(8'h0F, rd); check("resv_f", rd, 32'h0);
    bus_write(8'h08, 32'h5);
    bus_read(8'h08, rd); check("count_ro", rd, 32'h0);
    bus_write(8'h13, 32'h12345678);
    bus_read(8'h03, rd); check("hi_addr_data", rd, 32'h12345678);
    bus_read(8'h08, rd); check("hi_addr_count", rd, 32'h1);

    // Reset in the middle of a cycle with interrupt active
    fill_all();
    check("pre_rst_int", 32'(s_interrupt), 32'h1);
    S_sel = 1'b1; S_wr = 1'b0; S_address = 8'h00;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", S_dout, 32'h0);
    check("mid_rst_int", 32'(s_interrupt), 32'h0);
    check("mid_rst_full", 32'(s_full), 32'h0);
    S_sel = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read(8'h00, rd); check("post_rst_data0", rd, 32'h0);
    bus_read(8'h09, rd); check("post_rst_ctrl", rd, 32'h0);
    bus_read(8'h08, rd); check("post_rst_count", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
